// File: rtl/pre_if_fetch_gen_if.sv
// Instruction-memory fetch request bus: req/addr with an addr_ok acceptance handshake.
interface pre_if_fetch_gen_if #(
  parameter int unsigned PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            addr_ok;

  modport master (output req, output addr, input addr_ok);
  modport slave  (input req, input addr, output addr_ok);
endinterface

// File: rtl/pre_if_fetch_gen.sv
// Next-PC generator and fetch-request stage ahead of IF; holds requests until accepted.
// Optional PRE_IF_PERF_CNT_EN adds saturating fetch/cancel/hold performance counters.
module pre_if_fetch_gen #(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(32'h1c000000),
  parameter int unsigned     FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              from_allowin,
  pre_if_fetch_gen_if.master imem,
  output logic              to_valid,
  output logic [PC_W-1:0]   to_pc,
  output logic              to_cancel
`ifdef PRE_IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_cancel_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  localparam logic [PC_W-1:0] STEP       = PC_W'(FETCH_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - PC_W'(1));

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            valid_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] hold_addr_q, hold_addr_d;
  logic            pend_valid_q, pend_valid_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            pend_ex_q, pend_ex_d;
  logic            stale_q, stale_d;

  logic            redirect;
  logic [PC_W-1:0] redir_target;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] nextpc;
  logic            req_c;
  logic [PC_W-1:0] addr_c;
  logic            cancel_c;

  // Redirect priority: exception beats branch beats buffered redirect beats sequential.
  assign redirect     = ex_taken | br_taken;
  assign redir_target = ex_taken ? ex_target : br_target;
  assign seq_pc       = (pc_q & ALIGN_MASK) + STEP;
  assign nextpc       = redirect ? redir_target : (pend_valid_q ? pend_target_q : seq_pc);

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_addr_d   = hold_addr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_ex_d     = pend_ex_q;
    stale_d       = stale_q;
    req_c         = 1'b0;
    addr_c        = nextpc;
    cancel_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_c  = valid_q & from_allowin;
        addr_c = nextpc;
        if (req_c && imem.addr_ok) begin
          pc_d         = nextpc;
          pend_valid_d = 1'b0;
          pend_ex_d    = 1'b0;
        end else if (req_c) begin
          // The pending redirect is consumed into the held address.
          hold_addr_d  = nextpc;
          pend_valid_d = 1'b0;
          pend_ex_d    = 1'b0;
          state_d      = S_HOLD;
        end else if (valid_q && redirect) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redir_target;
          pend_ex_d     = ex_taken;
        end
      end

      S_HOLD: begin
        req_c  = 1'b1;
        addr_c = hold_addr_q;
        if (ex_taken) begin
          stale_d       = 1'b1;
          pend_valid_d  = 1'b1;
          pend_target_d = ex_target;
          pend_ex_d     = 1'b1;
        end else if (br_taken) begin
          stale_d      = 1'b1;
          pend_valid_d = 1'b1;
          // A buffered exception target is never displaced by a younger branch.
          if (!(pend_valid_q && pend_ex_q)) begin
            pend_target_d = br_target;
            pend_ex_d     = 1'b0;
          end
        end
        if (imem.addr_ok) begin
          cancel_c = stale_q | redirect;
          pc_d     = hold_addr_q;
          stale_d  = 1'b0;
          state_d  = S_IDLE;
          if (!cancel_c) begin
            pend_valid_d = 1'b0;
            pend_ex_d    = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A request in flight is abandoned as soon as reset is seen.
    if (reset) req_c = 1'b0;
  end

  assign imem.req  = req_c;
  assign imem.addr = addr_c;
  assign to_valid  = req_c & imem.addr_ok;
  assign to_pc     = addr_c;
  assign to_cancel = to_valid & cancel_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      pc_q          <= RESET_PC - STEP;
      hold_addr_q   <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_ex_q     <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= 1'b1;
      pc_q          <= pc_d;
      hold_addr_q   <= hold_addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_ex_q     <= pend_ex_d;
      stale_q       <= stale_d;
    end
  end

`ifdef PRE_IF_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_cancel_cnt <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if (to_valid && !to_cancel && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (to_valid && to_cancel && (perf_cancel_cnt != 32'hFFFF_FFFF))
        perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
      if ((state_q == S_HOLD) && (perf_hold_cnt != 32'hFFFF_FFFF))
        perf_hold_cnt <= perf_hold_cnt + 32'd1;
    end
  end
`endif

endmodule
